// File: rtl/decode_wb_param.sv
// Decode-stage operand forwarding and writeback register file, with architectural status and a retired-instruction counter.
// Latency: d_valA/d_valB are combinational; register writes, stat, halted and retired update on the clk edge.
// Backpressure: none. Every edge commits writeback, and a stop status freezes writes and status until reset.
// Ports: clk/rst_n (synchronous active-low); d_srcA/d_srcB/sel_valP/D_valP are the decode read request;
//   e_*, M_*, m_valM and W_* are the pipeline forwarding sources and the writeback port; W_stat is the writeback status;
//   d_valA/d_valB are the forwarded operands; stat/halted/retired are the architectural status and the count.
module decode_wb_param #(
  parameter int                DATA_W  = 64,
  parameter int                AW      = 4,
  parameter int                SP_ID   = 4,
  parameter logic [DATA_W-1:0] SP_INIT = '0,
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     d_srcA,
  input  logic [AW-1:0]     d_srcB,
  input  logic              sel_valP,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [AW-1:0]     e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [AW-1:0]     M_dstE,
  input  logic [AW-1:0]     M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [AW-1:0]     W_dstE,
  input  logic [AW-1:0]     W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [2:0]        W_stat,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int            NREG  = (1 << AW) - 1;
  localparam logic [AW-1:0] RNONE = '1;

  localparam logic [2:0] ST_BUB = 3'd0;
  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // The all-ones ID means "no register", so it gets no storage.
  logic [DATA_W-1:0] r_regs [NREG];
  logic [2:0]        r_stat;
  logic              r_halted;
  logic [CNT_W-1:0]  r_retired;

  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;

  // Youngest producer wins. Because src is already known not to be RNONE,
  // a source tagged RNONE can never match it.
  function automatic logic [DATA_W-1:0] fwd_pick(input logic [AW-1:0]     src,
                                                 input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] v;
    v = rf_val;
    if (src == RNONE)       v = '0;
    else if (src == e_dstE) v = e_valE;
    else if (src == M_dstM) v = m_valM;
    else if (src == M_dstE) v = M_valE;
    else if (src == W_dstM) v = W_valM;
    else if (src == W_dstE) v = W_valE;
    return v;
  endfunction

  always_comb begin
    w_rf_a = '0;
    w_rf_b = '0;
    if (d_srcA != RNONE) w_rf_a = r_regs[d_srcA];
    if (d_srcB != RNONE) w_rf_b = r_regs[d_srcB];
  end

  always_comb begin
    d_valA = fwd_pick(d_srcA, w_rf_a);
    if (sel_valP) d_valA = D_valP;
    d_valB = fwd_pick(d_srcB, w_rf_b);
  end

  // Register file. The M write is issued after the E write, so it takes
  // precedence when both target the same ID on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_ID) ? SP_INIT : '0;
      end
    end else if (!r_halted) begin
      if (W_dstE != RNONE) r_regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) r_regs[W_dstM] <= W_valM;
    end
  end

  // Status and retire counter. The instruction that raises a stop code still
  // commits its writes, because halted only rises after that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat    <= ST_AOK;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else if (!r_halted) begin
      case (W_stat)
        ST_BUB: ;
        ST_AOK: begin
          r_stat    <= ST_AOK;
          r_retired <= r_retired + CNT_ONE;
        end
        ST_HLT: begin
          r_stat    <= ST_HLT;
          r_halted  <= 1'b1;
          r_retired <= r_retired + CNT_ONE;
        end
        ST_ADR: begin
          r_stat   <= ST_ADR;
          r_halted <= 1'b1;
        end
        default: begin
          // INS and the undefined codes 5-7 all stop as INS.
          r_stat   <= ST_INS;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign stat    = r_stat;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule
